local_average_filter_v3: RTL
============================

Name: local_average_filter_v3

Overview:
- Parametrised successor to the running-window local average filter in the gray_in path; sits between pixel ingest and the block-matching threshold stage.
- Computes a causal moving average over the last WINDOW = 2*RADIUS valid pixels.
- Adds configurable pixel width, line-aware window restart, edge handling (zero-fill or first-pixel replicate), optional rounding, a window-full flag, and a line-start marker.
- Output average is cycle-aligned with the delayed pixel.

Parameters:
- PIX_W, 8, grey pixel width; input/output pixel bus is PIX_W+1 bits with SOF at MSB.
- RADIUS, 8, half window; WINDOW = 2*RADIUS must be a power of two, with RADIUS >= 1.
- LINE_WIDTH, 640, valid pixels per line, >= 2; the window restarts at each line start.
- EDGE_MODE, 0, 0 = zero-fill at line start, 1 = replicate first pixel of the line across the window.
- ROUND, 0, 0 = truncate, 1 = round half up.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- pixel  in  PIX_W+1  [PIX_W] = SOF, [PIX_W-1:0] = grey value
- pixel_valid  in  1  qualifies pixel; no backpressure
- out_pixel  out  PIX_W+1  pixel delayed 1 cycle
- out_pixel_valid  out  1  qualifies out_pixel
- local_average  out  PIX_W  window average including out_pixel
- local_average_valid  out  1  equals out_pixel_valid
- window_full  out  1  window holds WINDOW real samples
- line_start  out  1  out_pixel is column 0 of a line

Behaviour:
- Reset asserted (low):
  - All outputs are 0.
  - Shift register and sum are 0; column = 0 and fill = 0.
  - Takes effect immediately, including mid-line; the first pixel after release is treated as a line start.
- Internal widths:
  - SHIFT = log2(WINDOW).
  - sum is PIX_W+SHIFT bits; the rounding add uses 1 extra bit.
  - No saturation is needed, because the result is always <= 2^PIX_W-1.
- Line start: a valid pixel with column == 0 OR SOF == 1. SOF forces column to 0 regardless of the counter.
- Column counter:
  - Increments per valid pixel.
  - Wraps LINE_WIDTH-1 -> 0.
  - After an SOF pixel, the next column is 1.
- Per valid pixel p:
  - Line start, EDGE_MODE=0: sreg = {0,...,0,p}; sum_next = p; fill_next = 1.
  - Line start, EDGE_MODE=1: all sreg entries = p; sum_next = p*WINDOW (shift left); fill_next = WINDOW.
  - Otherwise: sreg shifts in p; sum_next = sum + p - sreg[WINDOW-1]; fill_next = min(fill+1, WINDOW).
- Output register, latency exactly 1 cycle after pixel_valid:
  - out_pixel <= pixel.
  - out_pixel_valid and local_average_valid <= 1.
  - local_average <= (sum_next + (ROUND ? WINDOW/2 : 0)) >> SHIFT.
  - window_full <= (fill_next == WINDOW).
  - line_start <= line-start condition.
- pixel_valid low:
  - Valids and line_start go to 0.
  - out_pixel, local_average and window_full hold.
  - Internal state is unchanged; gaps do not age the window.
- Back-to-back valid pixels are sustained at 1 per clock.
- SOF and a counter wrap in the same cycle form a single line start.

Decomposition:
- Package lavg_pkg holds:
  - edge_mode_e enum (EDGE_ZERO, EDGE_REPLICATE).
  - localparam helper functions for WINDOW, SHIFT and SUM_W.
  - An elaboration-time assertion function checking WINDOW is a power of two.
- Sub-module line_position_counter (LINE_WIDTH parameter): valid/SOF in; column and line_start_now out.
- The top level holds the window sreg, sum datapath and output register.

Test Plan (PIX_W=8, RADIUS=2 so WINDOW=4, LINE_WIDTH=8 unless noted):
1. Zero-fill fill-up: EDGE_MODE=0, ROUND=0, constant 100 from reset, SOF on first pixel -> averages 25, 50, 75, 100, 100…; window_full rises on the 4th output; line_start=1 on the 1st output only.
2. Replicate: EDGE_MODE=1, first pixel 100 then 20 -> averages 100 then 80; window_full=1 from the first output.
3. Line wrap: 8 pixels of 200, then a 9th pixel of 0 with no SOF, EDGE_MODE=0 -> 9th average 0 (not 150); line_start=1 on the 9th output.
4. Mid-line SOF and rounding: SOF at column 5 restarts the window (average = p>>2). With ROUND=1, pixels 1,1 -> averages 0, 1; with ROUND=0 -> 0, 0. Constant 255 with ROUND=1 -> 255, no overflow.
5. Gaps and async reset:
   - pixel_valid pattern 1,0,0,1 with values 40, x, x, 40 -> the 2nd average is 20; outputs hold during the gap.
   - Asserting reset low mid-line clears outputs without a clock edge.
   - After release, the first pixel is treated as a line start.

Source files
------------

// File: rtl/lavg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lavg_pkg
// Brief    : Shared types and width helpers for the local average filter.
// Revision : 3.0
// ============================================================================
package lavg_pkg;

  typedef enum logic [0:0] {
    EDGE_ZERO      = 1'b0,
    EDGE_REPLICATE = 1'b1
  } edge_mode_e;

  function automatic int lavg_window(input int radius);
    return 2 * radius;
  endfunction

  function automatic int lavg_shift(input int radius);
    return $clog2(2 * radius);
  endfunction

  function automatic int lavg_sum_w(input int pix_w, input int radius);
    return pix_w + $clog2(2 * radius);
  endfunction

  function automatic int lavg_col_w(input int line_width);
    return $clog2(line_width);
  endfunction

  // True when the window length is a non-zero power of two.
  function automatic bit lavg_window_ok(input int window);
    return (window > 0) && ((window & (window - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_position_counter.sv
`default_nettype none
// ============================================================================
// Module   : line_position_counter
// Brief    : Column tracker; flags the pixel that opens a line (column 0 or SOF).
// Revision : 3.0
// ============================================================================
module line_position_counter
  import lavg_pkg::*;
#(
  parameter int LINE_WIDTH = 640,
  parameter int COL_W      = lavg_col_w(LINE_WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic             sof,
  output logic [COL_W-1:0] column,
  output logic             line_start_now
);

  logic [COL_W-1:0] r_column;
  logic [COL_W-1:0] w_eff_col;

  // SOF pins the current pixel to column 0, so the following one lands on 1.
  assign w_eff_col      = sof ? '0 : r_column;
  assign line_start_now = valid && ((r_column == '0) || sof);
  assign column         = r_column;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_column <= '0;
    end else if (valid) begin
      if (w_eff_col == COL_W'(LINE_WIDTH - 1)) begin
        r_column <= '0;
      end else begin
        r_column <= w_eff_col + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/local_average_filter_v3.sv
`default_nettype none
// ============================================================================
// Module   : local_average_filter_v3
// Brief    : Causal line-aware moving average over the last 2*RADIUS pixels.
// Revision : 3.0
// ============================================================================
module local_average_filter_v3
  import lavg_pkg::*;
#(
  parameter int PIX_W      = 8,
  parameter int RADIUS     = 8,
  parameter int LINE_WIDTH = 640,
  parameter int EDGE_MODE  = 0,
  parameter int ROUND      = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W:0]   pixel,
  input  logic             pixel_valid,
  output logic [PIX_W:0]   out_pixel,
  output logic             out_pixel_valid,
  output logic [PIX_W-1:0] local_average,
  output logic             local_average_valid,
  output logic             window_full,
  output logic             line_start
);

  localparam int c_WINDOW = lavg_window(RADIUS);
  localparam int c_SHIFT  = lavg_shift(RADIUS);
  localparam int c_SUM_W  = lavg_sum_w(PIX_W, RADIUS);
  localparam int c_COL_W  = lavg_col_w(LINE_WIDTH);
  localparam int c_FILL_W = $clog2(c_WINDOW + 1);
  localparam edge_mode_e      c_EDGE      = (EDGE_MODE != 0) ? EDGE_REPLICATE : EDGE_ZERO;
  localparam logic [c_SUM_W:0] c_ROUND_ADD = (ROUND != 0) ? (c_SUM_W + 1)'(c_WINDOW / 2) : '0;

  generate
    if (!lavg_window_ok(c_WINDOW) || (RADIUS < 1)) begin : g_bad_window
      $error("local_average_filter_v3: 2*RADIUS must be a power of two");
    end
  endgenerate

  logic [c_COL_W-1:0]  w_column;
  logic                w_line_start_now;
  logic [PIX_W-1:0]    w_grey;
  logic [PIX_W-1:0]    r_sreg      [c_WINDOW];
  logic [PIX_W-1:0]    w_sreg_next [c_WINDOW];
  logic [c_SUM_W-1:0]  r_sum;
  logic [c_SUM_W-1:0]  w_sum_next;
  logic [c_FILL_W-1:0] r_fill;
  logic [c_FILL_W-1:0] w_fill_next;
  logic [c_SUM_W:0]    w_round_sum;
  logic [PIX_W-1:0]    w_avg;
  logic                w_unused_bits;

  line_position_counter #(
    .LINE_WIDTH (LINE_WIDTH),
    .COL_W      (c_COL_W)
  ) u_line_position_counter (
    .clk            (clk),
    .reset          (reset),
    .valid          (pixel_valid),
    .sof            (pixel[PIX_W]),
    .column         (w_column),
    .line_start_now (w_line_start_now)
  );

  assign w_grey = pixel[PIX_W-1:0];

  always_comb begin
    w_sreg_next = r_sreg;
    w_sum_next  = r_sum;
    w_fill_next = r_fill;
    if (w_line_start_now) begin
      if (c_EDGE == EDGE_REPLICATE) begin
        for (int i = 0; i < c_WINDOW; i++) begin
          w_sreg_next[i] = w_grey;
        end
        w_sum_next  = {w_grey, {c_SHIFT{1'b0}}};
        w_fill_next = c_FILL_W'(c_WINDOW);
      end else begin
        for (int i = 0; i < c_WINDOW; i++) begin
          w_sreg_next[i] = '0;
        end
        w_sreg_next[0] = w_grey;
        w_sum_next     = c_SUM_W'(w_grey);
        w_fill_next    = c_FILL_W'(1);
      end
    end else begin
      w_sreg_next[0] = w_grey;
      for (int i = 1; i < c_WINDOW; i++) begin
        w_sreg_next[i] = r_sreg[i-1];
      end
      // The sum always contains the oldest entry, so this never underflows.
      w_sum_next  = r_sum + c_SUM_W'(w_grey) - c_SUM_W'(r_sreg[c_WINDOW-1]);
      w_fill_next = (r_fill == c_FILL_W'(c_WINDOW)) ? r_fill : r_fill + 1'b1;
    end
  end

  assign w_round_sum   = {1'b0, w_sum_next} + c_ROUND_ADD;
  assign w_avg         = w_round_sum[c_SHIFT +: PIX_W];
  assign w_unused_bits = ^{w_round_sum[c_SUM_W], w_round_sum[c_SHIFT-1:0], w_column};

  // Window state only advances on valid pixels; gaps do not age it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < c_WINDOW; i++) begin
        r_sreg[i] <= '0;
      end
      r_sum  <= '0;
      r_fill <= '0;
    end else if (pixel_valid) begin
      r_sreg <= w_sreg_next;
      r_sum  <= w_sum_next;
      r_fill <= w_fill_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_pixel           <= '0;
      out_pixel_valid     <= 1'b0;
      local_average       <= '0;
      local_average_valid <= 1'b0;
      window_full         <= 1'b0;
      line_start          <= 1'b0;
    end else begin
      out_pixel_valid     <= pixel_valid;
      local_average_valid <= pixel_valid;
      line_start          <= w_line_start_now;
      if (pixel_valid) begin
        out_pixel     <= pixel;
        local_average <= w_avg;
        window_full   <= (w_fill_next == c_FILL_W'(c_WINDOW));
      end
    end
  end

endmodule
`default_nettype wire
